// File: rtl/screen_pkg.sv
// Shared types for the CPU-side screen RAM master.
//   cmd_op_t       - command opcodes carried on cmd_op (all four codes are defined)
//   writer_state_t - FSM states of screen_ram_writer
package screen_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_FILL  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_READ  = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FILL,
        READ_ADDR,
        READ_WAIT,
        DONE
    } writer_state_t;

endpackage

// File: rtl/screen_ram_writer.sv
// CPU-side write/read master for the screen RAM.
// Takes single-word commands over a valid/ready handshake and drives a synchronous RAM port.
// Supported operations are single write, block fill, screen clear and single read.
// Ports:
//   CLK_50, reset          clock (rising edge) and synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake; ready is high only when idle or in the done cycle
//   cmd_op/addr/data/count command fields, sampled at acceptance only
//   rsp_valid/rsp_data     read result; one-cycle pulse, data held until the next read
//   done                   one-cycle pulse when any command completes
//   ram_addr/we/wdata      RAM write/read port (all registered)
//   ram_rdata              RAM read data, valid one cycle after ram_addr
module screen_ram_writer
    import screen_pkg::*;
#(
    parameter int unsigned RAM_WIDTH          = 16,
    parameter int unsigned RAM_REGISTER_COUNT = 256,
    parameter int unsigned RAM_SCREEN_OFFSET  = 0,
    parameter int unsigned SCREEN_WORDS       = 32,
    localparam int unsigned ADDR_W            = $clog2(RAM_REGISTER_COUNT),
    localparam int unsigned CNT_W             = ADDR_W + 1
) (
    input  logic                 CLK_50,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [RAM_WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0]     cmd_count,
    output logic                 rsp_valid,
    output logic [RAM_WIDTH-1:0] rsp_data,
    output logic                 done,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_we,
    output logic [RAM_WIDTH-1:0] ram_wdata,
    input  logic [RAM_WIDTH-1:0] ram_rdata
);

    writer_state_t        state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [RAM_WIDTH-1:0] wdata_q, wdata_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [RAM_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;

    logic                 accept;
    logic                 is_clear;
    logic [ADDR_W-1:0]    fill_addr;
    logic [CNT_W-1:0]     fill_count;
    logic [RAM_WIDTH-1:0] fill_data;
    logic [ADDR_W-1:0]    addr_inc;

    assign accept = cmd_valid && ready_q;

    // CLEAR is a FILL with fixed region and zero pattern.
    assign is_clear   = (cmd_op == OP_CLEAR);
    assign fill_addr  = is_clear ? ADDR_W'(RAM_SCREEN_OFFSET) : cmd_addr;
    assign fill_count = is_clear ? CNT_W'(SCREEN_WORDS) : cmd_count;
    assign fill_data  = is_clear ? '0 : cmd_data;

    // Explicit wrap keeps the modulo behaviour for non-power-of-two depths.
    assign addr_inc = (addr_q == ADDR_W'(RAM_REGISTER_COUNT - 1)) ? '0 : addr_q + ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;

        unique case (state_q)
            // DONE behaves like IDLE so a command can be taken back-to-back.
            IDLE, DONE: begin
                state_d = IDLE;
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    unique case (cmd_op_t'(cmd_op))
                        OP_WRITE: begin
                            state_d = WRITE;
                            we_d    = 1'b1;
                            addr_d  = cmd_addr;
                            wdata_d = cmd_data;
                        end
                        OP_FILL, OP_CLEAR: begin
                            if (fill_count == '0) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                                ready_d = 1'b1;
                            end else begin
                                state_d     = FILL;
                                we_d        = 1'b1;
                                addr_d      = fill_addr;
                                wdata_d     = fill_data;
                                remaining_d = fill_count;
                            end
                        end
                        OP_READ: begin
                            state_d = READ_ADDR;
                            addr_d  = cmd_addr;
                        end
                    endcase
                end
            end
            WRITE: begin
                state_d = DONE;
                done_d  = 1'b1;
                ready_d = 1'b1;
            end
            FILL: begin
                // remaining_q counts the write on the port this cycle.
                if (remaining_q > CNT_W'(1)) begin
                    we_d        = 1'b1;
                    addr_d      = addr_inc;
                    remaining_d = remaining_q - CNT_W'(1);
                end else begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    ready_d     = 1'b1;
                    remaining_d = '0;
                end
            end
            READ_ADDR: begin
                state_d = READ_WAIT;
            end
            READ_WAIT: begin
                state_d     = DONE;
                rsp_data_d  = ram_rdata;
                rsp_valid_d = 1'b1;
                done_d      = 1'b1;
                ready_d     = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
        end
    end

    assign cmd_ready = ready_q;
    assign ram_we    = we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign done      = done_q;

endmodule

// File: tb/tb_screen_ram_writer.sv
// Bench for screen_ram_writer: directed vector table, a mid-fill reset sequence and random
// commands, all checked against a word-array model of the RAM contents.
module tb_screen_ram_writer;

    logic        CLK_50 = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic [8:0]  cmd_count;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        done;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    always #10 CLK_50 = ~CLK_50;

    screen_ram_writer dut (
        .CLK_50    (CLK_50),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .done      (done),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Synchronous RAM attached to the DUT, prefilled with 0xFFFF.
    logic [15:0] mem [256] = '{default: 16'hFFFF};
    always @(posedge CLK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Reference contents: what the RAM must hold after every completed command.
    logic [15:0] ref_mem [256] = '{default: 16'hFFFF};
    logic [15:0] last_rsp;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [15:0] data;
        logic [8:0]  count;
        bit          hold;
        int          exp_lat;
        logic [15:0] exp_rsp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command at a negedge, follow it to its done cycle, and check everything it did.
    // Returns at the negedge of the done cycle so the next command can go back-to-back.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [15:0] d,
                           input logic [8:0] n, input bit hold,
                           output int lat, output logic [15:0] rsp);
        wr_t         exp_q[$];
        wr_t         obs_q[$];
        int          exp_lat;
        int          n_eff;
        int          ready_low;
        int          rsp_cnt;
        int          rsp_at;
        logic [7:0]  base;
        logic [15:0] pat;

        check("rsp_hold", rsp_data, last_rsp);
        check("ready_idle", cmd_ready, 1'b1);

        exp_lat = 3;
        case (op)
            2'd0: begin
                exp_q.push_back('{1, a, d});
                exp_lat = 2;
            end
            2'd1, 2'd2: begin
                base  = (op == 2'd2) ? 8'h00 : a;
                pat   = (op == 2'd2) ? 16'h0000 : d;
                n_eff = (op == 2'd2) ? 32 : int'(n);
                for (int i = 0; i < n_eff; i++)
                    exp_q.push_back('{i + 1, 8'((int'(base) + i) % 256), pat});
                exp_lat = n_eff + 1;
            end
            default: exp_lat = 3;
        endcase

        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_count = n;
        cmd_valid = 1'b1;
        @(posedge CLK_50);

        lat       = -1;
        rsp       = 16'h0;
        ready_low = 0;
        rsp_cnt   = 0;
        rsp_at    = -1;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            @(negedge CLK_50);
            // Busy-time inputs are garbage; the DUT must ignore them.
            cmd_valid = hold;
            cmd_op    = 2'($urandom);
            cmd_addr  = 8'($urandom);
            cmd_data  = 16'($urandom);
            cmd_count = 9'($urandom_range(0, 256));
            if (ram_we) obs_q.push_back('{c, ram_addr, ram_wdata});
            if (c == 1 && op == 2'd3) check("read_addr", ram_addr, a);
            if (!cmd_ready) ready_low++;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_at = c;
                rsp    = rsp_data;
            end
            if (done) lat = c;
        end
        cmd_valid = 1'b0;

        check("latency", lat, exp_lat);
        check("ready_low_cycles", ready_low, exp_lat - 1);
        check("write_count", obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size()) begin
            foreach (exp_q[i])
                check("write", {16'(obs_q[i].cyc), obs_q[i].a, obs_q[i].d},
                      {16'(exp_q[i].cyc), exp_q[i].a, exp_q[i].d});
        end
        if (op == 2'd3) begin
            check("rsp_count", rsp_cnt, 1);
            check("rsp_cycle", rsp_at, 3);
            check("rsp_data", rsp, ref_mem[a]);
            last_rsp = ref_mem[a];
        end else begin
            check("rsp_count", rsp_cnt, 0);
        end
        foreach (exp_q[i]) ref_mem[exp_q[i].a] = exp_q[i].d;
    endtask

    vec_t        vecs[12];
    int          lat;
    logic [15:0] rsp;
    int          cnt_done;
    int          cnt_we;
    int          bad_words;

    initial begin
        vecs[0]  = '{2'd0, 8'h05, 16'hBEEF, 9'd0,   1'b0, 2,   16'h0000};
        vecs[1]  = '{2'd1, 8'hFE, 16'h1234, 9'd4,   1'b0, 5,   16'h0000};
        vecs[2]  = '{2'd2, 8'h99, 16'hABCD, 9'd5,   1'b0, 33,  16'h0000};
        vecs[3]  = '{2'd0, 8'h10, 16'h00A5, 9'd0,   1'b0, 2,   16'h0000};
        vecs[4]  = '{2'd3, 8'h10, 16'h0000, 9'd0,   1'b0, 3,   16'h00A5};
        vecs[5]  = '{2'd3, 8'h05, 16'h0000, 9'd0,   1'b0, 3,   16'h0000};
        vecs[6]  = '{2'd3, 8'h20, 16'h0000, 9'd0,   1'b1, 3,   16'hFFFF};
        vecs[7]  = '{2'd1, 8'h30, 16'h4321, 9'd0,   1'b1, 1,   16'h0000};
        vecs[8]  = '{2'd1, 8'h80, 16'h1111, 9'd3,   1'b1, 4,   16'h0000};
        vecs[9]  = '{2'd1, 8'h00, 16'h7777, 9'd256, 1'b0, 257, 16'h0000};
        vecs[10] = '{2'd3, 8'hFF, 16'h0000, 9'd0,   1'b0, 3,   16'h7777};
        vecs[11] = '{2'd3, 8'h01, 16'h0000, 9'd0,   1'b1, 3,   16'h7777};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 8'h00;
        cmd_data  = 16'h0000;
        cmd_count = 9'd0;
        last_rsp  = 16'h0000;
        repeat (3) @(posedge CLK_50);
        @(negedge CLK_50);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_we", ram_we, 1'b0);
        check("rst_addr", ram_addr, 8'h00);
        check("rst_wdata", ram_wdata, 16'h0000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 16'h0000);
        check("rst_done", done, 1'b0);
        reset = 1'b0;
        @(negedge CLK_50);

        for (int i = 0; i < 12; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].count, vecs[i].hold,
                    lat, rsp);
            check("tbl_latency", lat, vecs[i].exp_lat);
            if (vecs[i].op == 2'd3) check("tbl_rsp", rsp, vecs[i].exp_rsp);
            if (i == 2) begin
                check("clear_word31", mem[31], 16'h0000);
                check("clear_word32", mem[32], 16'hFFFF);
            end
        end

        // Reset two cycles into a 10-word fill: two words land, nothing else follows.
        cmd_op    = 2'd1;
        cmd_addr  = 8'h40;
        cmd_data  = 16'h5A5A;
        cmd_count = 9'd10;
        cmd_valid = 1'b1;
        @(posedge CLK_50);
        @(negedge CLK_50);
        cmd_valid = 1'b0;
        check("rstfill_we1", {ram_we, ram_addr}, {1'b1, 8'h40});
        @(negedge CLK_50);
        check("rstfill_we2", {ram_we, ram_addr}, {1'b1, 8'h41});
        reset = 1'b1;
        @(negedge CLK_50);
        check("rstfill_we", ram_we, 1'b0);
        check("rstfill_ready", cmd_ready, 1'b1);
        check("rstfill_done", done, 1'b0);
        check("rstfill_addr", ram_addr, 8'h00);
        check("rstfill_rsp_data", rsp_data, 16'h0000);
        reset    = 1'b0;
        cnt_done = 0;
        cnt_we   = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK_50);
            if (done) cnt_done++;
            if (ram_we) cnt_we++;
        end
        check("rstfill_no_done", cnt_done, 0);
        check("rstfill_no_we", cnt_we, 0);
        ref_mem[8'h40] = 16'h5A5A;
        ref_mem[8'h41] = 16'h5A5A;
        last_rsp       = 16'h0000;

        for (int i = 0; i < 40; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 16'($urandom),
                    9'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), lat, rsp);
        end

        @(negedge CLK_50);
        bad_words = 0;
        for (int w = 0; w < 256; w++)
            if (mem[w] !== ref_mem[w]) bad_words++;
        check("ram_contents", bad_words, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
